muller_pipeline: RTL and testbench
==================================

# muller_pipeline

Parametrised, clocked 2-phase micropipeline built from a chain of DEPTH Muller C-element control stages, each gating a WIDTH-bit data register. It is the next generation of the single C-element project block: transition-signalled bundled-data handshakes on both sides, configurable depth and width, and optional synchronisers on the incoming handshake lines. It sits between the user-project IO pins and internal logic, or between two internal domains that exchange data by handshake.

## Interface

- WIDTH, 8: data bits per token (1..32).
- DEPTH, 4: number of C-element stages, which is also the token capacity (2..16).
- SYNC_STAGES, 2: flops on in_req and out_ack before use (0..3). A value of 0 means direct use.

- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_req  in  1  producer request; a toggle offers a token.
- in_data  in  WIDTH  bundled data; held stable while in_req != in_ack.
- in_ack  out  1  producer acknowledge; equals stage 0 control bit c[0].
- out_req  out  1  consumer request; equals c[DEPTH-1].
- out_data  out  WIDTH  equals d[DEPTH-1]; valid while out_req != out_ack.
- out_ack  in  1  consumer acknowledge; a toggle consumes the token.
- occupancy  out  $clog2(DEPTH+1)  tokens held (present only with MULLER_PIPE_OCC_EN).

## Operation

- State:
  - control bits c[0..DEPTH-1].
  - data registers d[0..DEPTH-1].
  - sync chains for in_req and out_ack, producing rq and ak.
- Boundary terms:
  - a[i] = c[i-1], with a[0] = rq.
  - b[i] = ~c[i+1], with b[DEPTH-1] = ~ak.
- C-element rule, evaluated per stage each edge from pre-edge values:
  - c[i] <= (a[i] & b[i]) | (c[i] & (a[i] | b[i])).
  - So c[i] toggles iff c[i-1] != c[i] (upstream token) and c[i+1] == c[i] (stage empty).
- Data capture: when c[i] toggles, d[i] <= d[i-1], with d[-1] = in_data.
  - d[i-1] cannot change in the same cycle, because its stage cannot toggle while holding a token.
- Token presence:
  - Stage i holds a token iff c[i] != c[i+1], with c[DEPTH] = ak.
  - Empty: all c equal ak.
  - Full: c alternates and c[DEPTH-1] != ak, giving DEPTH tokens.
- Full pipeline:
  - A new in_req toggle waits, with in_ack unchanged, until stage 0 empties.
  - No token is ever dropped or duplicated.
- Empty pipeline:
  - out_req == out_ack.
  - out_data holds the last delivered value.
- Simultaneous in_req and out_ack toggles are both honoured in the same edge when their stages qualify.
- Producer protocol violations (in_req toggling twice before in_ack) are undefined. The bench must not generate them.

## Timing

- Reset (asynchronous assert, released synchronously by the caller's reset tree):
  - c = 0, d = 0, sync flops = 0.
  - in_ack = 0, out_req = 0, out_data = 0, occupancy = 0.
- Reset mid-operation discards every token. The producer must return in_req to 0 and the consumer must return out_ack to 0 before the release.
- Forward latency, empty pipeline: out_req toggles SYNC_STAGES + DEPTH rising edges after the edge that samples the in_req toggle.
- Acknowledge latency: in_ack toggles SYNC_STAGES + 1 edges after the in_req toggle, if stage 0 is empty.
- Throughput: at most one token per 2 cycles per stage. The steady-state streaming rate is 1 token per 2 clk cycles plus handshake round trip.
- Backpressure release: after an out_ack toggle on a full pipeline, stage DEPTH-1 can accept its next token SYNC_STAGES + 1 edges later.

## Configuration

- MULLER_PIPE_OCC_EN:
  - Defined: the occupancy port exists and is registered. It equals the number of i with c[i] != c[i+1], updated on the same edge as c, and reads 0 from reset.
  - Undefined: the port and its counting logic are absent. All other behaviour is identical.

## Test plan

- Single token (WIDTH=8, DEPTH=4, SYNC_STAGES=2):
  - Stimulus: after reset, in_data=8'hA5, toggle in_req 0->1.
  - Required: in_ack=1 after 3 edges, out_req=1 after 6 edges, out_data=8'hA5. Toggle out_ack and pipeline reads empty.
- Fill to capacity with out_ack held:
  - Stimulus: send 8'h01..8'h05.
  - Required: in_ack follows the first 4 tokens, occupancy=4, and the 5th in_req toggle gets no in_ack.
  - Then toggle out_ack once: out_data=8'h01 is consumed, 8'h05 enters, and the output order is 01,02,03,04,05.
- Streaming: random data, consumer acknowledges 1 cycle after each out_req change.
  - Required: 64 tokens arrive in order, none lost or duplicated, and the sustained rate is no more than 1 token per 2 cycles.
- Simultaneous edges: with occupancy=2, toggle in_req and out_ack in the same cycle.
  - Required: occupancy stays 2 after settling and both handshakes complete.
- Reset mid-stream: assert rst_n=0 with 3 tokens held.
  - Required: in_ack, out_req, out_data and occupancy are all 0 immediately, without waiting for a clock edge.
  - After release, a new token 8'h3C delivers normally.
- SYNC_STAGES=0, DEPTH=2:
  - Stimulus: single token.
  - Required: in_ack toggles 1 edge after in_req, out_req after 2 edges.

Source files
------------

// File: rtl/muller_pipeline_if.sv
// rtl/muller_pipeline_if.sv - bundled-data 2-phase handshake bundle for muller_pipeline
//
// Purpose: groups the producer-side and consumer-side handshake lines of the
// micropipeline. The pipeline takes the slave view; the producer/consumer
// environment takes the master view.
// Signals:
//   in_req   producer request, a toggle offers a token
//   in_data  bundled data, stable while in_req != in_ack
//   in_ack   producer acknowledge
//   out_req  consumer request, a toggle presents a token
//   out_data bundled data, valid while out_req != out_ack
//   out_ack  consumer acknowledge, a toggle consumes the token
interface muller_pipeline_if #(
  parameter int WIDTH = 8
) ();
  logic             in_req;
  logic [WIDTH-1:0] in_data;
  logic             in_ack;
  logic             out_req;
  logic [WIDTH-1:0] out_data;
  logic             out_ack;

  modport master (
    output in_req, in_data, out_ack,
    input  in_ack, out_req, out_data
  );

  modport slave (
    input  in_req, in_data, out_ack,
    output in_ack, out_req, out_data
  );
endinterface

// File: rtl/muller_pipeline.sv
// rtl/muller_pipeline.sv - clocked 2-phase micropipeline of DEPTH Muller C-element stages
//
// Purpose: DEPTH-token FIFO built from C-element control stages, each gating a
// WIDTH-bit data register, with transition-signalled bundled-data handshakes
// on both sides and optional synchronisers on in_req/out_ack.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        muller_pipeline_if.slave (in_req/in_data/in_ack, out_req/out_data/out_ack)
//   occupancy  tokens held, only when MULLER_PIPE_OCC_EN is defined
// Parameters: WIDTH (1..32), DEPTH (2..16), SYNC_STAGES (0..3, 0 = direct use).
// Optional feature macro: MULLER_PIPE_OCC_EN (registered occupancy port).
module muller_pipeline #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  muller_pipeline_if.slave             bus
`ifdef MULLER_PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`endif
);

  logic             rq;
  logic             ak;
`ifdef MULLER_PIPE_OCC_EN
  logic             ak_nxt;
`endif

  logic [DEPTH-1:0] c_q, c_d;
  logic [DEPTH-1:0] a_vec, b_vec;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];

  // Handshake input synchronisers; bit 0 samples the pin, MSB feeds the stages.
  if (SYNC_STAGES > 0) begin : g_sync
    logic [SYNC_STAGES-1:0] rq_sync_q, rq_sync_d;
    logic [SYNC_STAGES-1:0] ak_sync_q, ak_sync_d;

    always_comb begin
      rq_sync_d = (rq_sync_q << 1) | SYNC_STAGES'(bus.in_req);
      ak_sync_d = (ak_sync_q << 1) | SYNC_STAGES'(bus.out_ack);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rq_sync_q <= '0;
        ak_sync_q <= '0;
      end else begin
        rq_sync_q <= rq_sync_d;
        ak_sync_q <= ak_sync_d;
      end
    end

    assign rq = rq_sync_q[SYNC_STAGES-1];
    assign ak = ak_sync_q[SYNC_STAGES-1];
`ifdef MULLER_PIPE_OCC_EN
    assign ak_nxt = ak_sync_d[SYNC_STAGES-1];
`endif
  end else begin : g_direct
    assign rq = bus.in_req;
    assign ak = bus.out_ack;
`ifdef MULLER_PIPE_OCC_EN
    assign ak_nxt = bus.out_ack;
`endif
  end

  // a[i] is the upstream control bit, b[i] the inverted downstream one.
  // The C-element output follows a/b when they agree and holds otherwise.
  always_comb begin
    a_vec = {c_q[DEPTH-2:0], rq};
    b_vec = ~{ak, c_q[DEPTH-1:1]};
    c_d   = c_q;
    for (int i = 0; i < DEPTH; i++) begin
      c_d[i] = (a_vec[i] & b_vec[i]) | (c_q[i] & (a_vec[i] | b_vec[i]));
    end
  end

  // A stage captures from upstream on its own toggle; the upstream register is
  // guaranteed stable that cycle because a stage holding a token cannot toggle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      d_d[i] = d_q[i];
    end
    if (c_d[0] != c_q[0]) begin
      d_d[0] = bus.in_data;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (c_d[i] != c_q[i]) begin
        d_d[i] = d_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      c_q <= c_d;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= d_d[i];
      end
    end
  end

  assign bus.in_ack   = c_q[0];
  assign bus.out_req  = c_q[DEPTH-1];
  assign bus.out_data = d_q[DEPTH-1];

`ifdef MULLER_PIPE_OCC_EN
  localparam int OCC_W = $clog2(DEPTH+1);

  logic [OCC_W-1:0] occ_q, occ_d;
  logic [DEPTH:0]   c_nxt_ext;

  // Counted from post-edge control bits so the count lands on the same edge as c.
  always_comb begin
    c_nxt_ext = {ak_nxt, c_d};
    occ_d     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + OCC_W'(c_nxt_ext[i] ^ c_nxt_ext[i+1]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;
`endif

endmodule

// File: tb/tb_muller_pipeline.sv
// tb/tb_muller_pipeline.sv - self-checking bench for muller_pipeline (4x8 sync=2 and 2x8 sync=0)
module tb_muller_pipeline;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  muller_pipeline_if #(.WIDTH(8)) if_a ();
  muller_pipeline_if #(.WIDTH(8)) if_b ();

`ifdef MULLER_PIPE_OCC_EN
  logic [2:0] occ_a;
  logic [1:0] occ_b;
`endif

  muller_pipeline #(.WIDTH(8), .DEPTH(4), .SYNC_STAGES(2)) u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (if_a)
`ifdef MULLER_PIPE_OCC_EN
    ,
    .occupancy (occ_a)
`endif
  );

  muller_pipeline #(.WIDTH(8), .DEPTH(2), .SYNC_STAGES(0)) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (if_b)
`ifdef MULLER_PIPE_OCC_EN
    ,
    .occupancy (occ_b)
`endif
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int rcv;
  int t0, t1;
  logic [7:0] mq [$];

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         sel;
    logic [7:0] data;
    int         ack_lat;
    int         req_lat;
  } tok_vec_t;

  typedef struct {
    logic [7:0] data;
    logic       accept;
  } fill_vec_t;

  tok_vec_t  tv [7];
  fill_vec_t fv [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic g_in_req(input int s);
    return (s != 0) ? if_b.in_req : if_a.in_req;
  endfunction
  function automatic logic g_in_ack(input int s);
    return (s != 0) ? if_b.in_ack : if_a.in_ack;
  endfunction
  function automatic logic g_out_req(input int s);
    return (s != 0) ? if_b.out_req : if_a.out_req;
  endfunction
  function automatic logic g_out_ack(input int s);
    return (s != 0) ? if_b.out_ack : if_a.out_ack;
  endfunction
  function automatic logic [7:0] g_out_data(input int s);
    return (s != 0) ? if_b.out_data : if_a.out_data;
  endfunction
`ifdef MULLER_PIPE_OCC_EN
  function automatic logic [2:0] g_occ(input int s);
    return (s != 0) ? {1'b0, occ_b} : occ_a;
  endfunction
`endif

  task automatic drive_req(input int s, input logic [7:0] d);
    if (s != 0) begin
      if_b.in_data = d;
      if_b.in_req  = ~if_b.in_req;
    end else begin
      if_a.in_data = d;
      if_a.in_req  = ~if_a.in_req;
    end
  endtask

  task automatic toggle_ack(input int s);
    if (s != 0) if_b.out_ack = ~if_b.out_ack;
    else        if_a.out_ack = ~if_a.out_ack;
  endtask

  task automatic wait_ack(input int s, input int lim, output logic got);
    got = 1'b0;
    for (int e = 0; e < lim && !got; e++) begin
      @(negedge clk);
      if (g_in_ack(s) == g_in_req(s)) got = 1'b1;
    end
  endtask

  // Send one token into DUT a, recording it in the reference queue.
  task automatic send_a(input logic [7:0] d, input string name);
    logic got;
    @(negedge clk);
    mq.push_back(d);
    drive_req(0, d);
    wait_ack(0, 20, got);
    check(name, got, 1'b1);
  endtask

  // Consume n tokens from DUT a, comparing each with the reference queue head.
  task automatic drain_a(input int n, input string name);
    for (int k = 0; k < n; k++) begin
      logic found;
      logic [7:0] exp_d;
      found = 1'b0;
      for (int e = 0; e < 30 && !found; e++) begin
        @(negedge clk);
        if (if_a.out_req != if_a.out_ack) found = 1'b1;
      end
      check({name, "_present"}, found, 1'b1);
      if (!found) return;
      exp_d = (mq.size() > 0) ? mq.pop_front() : 8'hxx;
      check({name, "_data"}, if_a.out_data, exp_d);
      toggle_ack(0);
    end
  endtask

  initial begin
    tv[0] = '{0, 8'hA5, 3, 6};
    tv[1] = '{0, 8'h5A, 3, 6};
    tv[2] = '{0, 8'hFF, 3, 6};
    tv[3] = '{0, 8'h00, 3, 6};
    tv[4] = '{1, 8'hA5, 1, 2};
    tv[5] = '{1, 8'h3C, 1, 2};
    tv[6] = '{1, 8'h81, 1, 2};
    fv[0] = '{8'h01, 1'b1};
    fv[1] = '{8'h02, 1'b1};
    fv[2] = '{8'h03, 1'b1};
    fv[3] = '{8'h04, 1'b1};
    fv[4] = '{8'h05, 1'b0};

    rst_n = 1'b0;
    if_a.in_req = 1'b0; if_a.in_data = '0; if_a.out_ack = 1'b0;
    if_b.in_req = 1'b0; if_b.in_data = '0; if_b.out_ack = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_in_ack_a",   if_a.in_ack,   1'b0);
    check("rst_out_req_a",  if_a.out_req,  1'b0);
    check("rst_out_data_a", if_a.out_data, 8'h00);
    check("rst_in_ack_b",   if_b.in_ack,   1'b0);
    check("rst_out_req_b",  if_b.out_req,  1'b0);
    check("rst_out_data_b", if_b.out_data, 8'h00);
`ifdef MULLER_PIPE_OCC_EN
    check("rst_occ_a", occ_a, 3'd0);
    check("rst_occ_b", occ_b, 2'd0);
`endif

    // Single tokens into an empty pipeline: latency and data
    for (int k = 0; k < 7; k++) begin
      int s, e, ea, er;
      s = tv[k].sel;
      @(negedge clk);
      drive_req(s, tv[k].data);
      e = 0; ea = -1; er = -1;
      while (er < 0 && e < 40) begin
        @(negedge clk);
        e++;
        if (ea < 0 && g_in_ack(s) == g_in_req(s)) ea = e;
        if (g_out_req(s) != g_out_ack(s)) er = e;
      end
      check("tok_ack_latency", ea, tv[k].ack_lat);
      check("tok_req_latency", er, tv[k].req_lat);
      check("tok_out_data", g_out_data(s), tv[k].data);
      toggle_ack(s);
      repeat (6) @(negedge clk);
      check("tok_empty_after_ack", g_out_req(s) ^ g_out_ack(s), 1'b0);
      check("tok_out_data_held", g_out_data(s), tv[k].data);
`ifdef MULLER_PIPE_OCC_EN
      check("tok_occ_empty", g_occ(s), 3'd0);
`endif
    end

    // Fill DUT a to capacity with out_ack held
    for (int k = 0; k < 5; k++) begin
      logic got;
      @(negedge clk);
      mq.push_back(fv[k].data);
      drive_req(0, fv[k].data);
      wait_ack(0, 12, got);
      check("fill_accept", got, fv[k].accept);
    end
`ifdef MULLER_PIPE_OCC_EN
    check("fill_occ_full", occ_a, 3'd4);
`endif
    check("fill_head", if_a.out_data, 8'h01);
    drain_a(5, "fill_drain");
    repeat (8) @(negedge clk);
    check("fill_late_ack", if_a.in_ack == if_a.in_req, 1'b1);
    check("fill_empty", if_a.out_req ^ if_a.out_ack, 1'b0);

    // Simultaneous in_req and out_ack toggles at occupancy 2
    send_a(8'h71, "sim_pre_ack");
    send_a(8'h72, "sim_pre_ack");
    repeat (10) @(negedge clk);
`ifdef MULLER_PIPE_OCC_EN
    check("sim_occ_before", occ_a, 3'd2);
`endif
    @(negedge clk);
    begin
      logic got;
      check("sim_consumed", if_a.out_data, mq.pop_front());
      mq.push_back(8'hC7);
      drive_req(0, 8'hC7);
      toggle_ack(0);
      wait_ack(0, 20, got);
      check("sim_in_ack", got, 1'b1);
    end
    repeat (10) @(negedge clk);
`ifdef MULLER_PIPE_OCC_EN
    check("sim_occ_after", occ_a, 3'd2);
`endif
    check("sim_token_present", if_a.out_req != if_a.out_ack, 1'b1);
    drain_a(2, "sim_drain");
    repeat (8) @(negedge clk);

    // Reset mid-stream with 3 tokens held
    send_a(8'h11, "rstm_ack");
    send_a(8'h22, "rstm_ack");
    send_a(8'h33, "rstm_ack");
    repeat (8) @(negedge clk);
    check("rstm_held", if_a.out_data, 8'h11);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstm_in_ack",   if_a.in_ack,   1'b0);
    check("rstm_out_req",  if_a.out_req,  1'b0);
    check("rstm_out_data", if_a.out_data, 8'h00);
`ifdef MULLER_PIPE_OCC_EN
    check("rstm_occ", occ_a, 3'd0);
`endif
    if_a.in_req  = 1'b0;
    if_a.out_ack = 1'b0;
    if_b.in_req  = 1'b0;
    if_b.out_ack = 1'b0;
    mq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_a(8'h3C, "rstm_new_ack");
    drain_a(1, "rstm_new");
    repeat (8) @(negedge clk);

    // Randomized streaming against the reference queue
    rcv = 0;
    t0  = cyc;
    fork
      begin
        for (int k = 0; k < 64; k++) begin
          logic got;
          logic [7:0] d;
          @(negedge clk);
          d = 8'($urandom);
          mq.push_back(d);
          drive_req(0, d);
          wait_ack(0, 60, got);
          check("stream_in_ack", got, 1'b1);
          if (!got) break;
        end
      end
      begin
        int idle;
        idle = 0;
        while (rcv < 64 && idle < 200) begin
          @(negedge clk);
          if (if_a.out_req != if_a.out_ack) begin
            check("stream_data", if_a.out_data, (mq.size() > 0) ? mq.pop_front() : 8'hxx);
            @(negedge clk);
            toggle_ack(0);
            rcv++;
            idle = 0;
          end else begin
            idle++;
          end
        end
        t1 = cyc;
      end
    join
    check("stream_count", rcv, 64);
    check("stream_leftover", mq.size(), 0);
    check("stream_rate_bound", (t1 - t0) >= 2 * 64, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
